// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - keyboard/AI driven paddle position controller for one PONG player
//
// Ports:
//   i_CLK, i_RST_N   clock, asynchronous active-low reset
//   i_frame_tick     one-cycle pulse per video frame; the only time y moves
//   i_key_valid      strobe qualifying i_key_byte
//   i_key_byte       ASCII key code (UP / DOWN / STOP, others ignored)
//   i_ai_en          level; rising edge enters AI tracking, falling edge leaves it
//   i_ball_y         ball top y, tracked in AI mode
//   o_y_pos          paddle top y, always within [Y_MIN, Y_MAX]
//   o_speed          current speed in lines per frame
//   o_state          00 IDLE, 01 UP, 10 DOWN, 11 AI
//   o_at_top/o_at_bot  paddle sits on the top/bottom bound
module paddle_ctrl #(
    parameter int UP           = 119,
    parameter int DOWN         = 115,
    parameter int STOP         = 32,
    parameter int Y_W          = 10,
    parameter int SCREEN_H     = 480,
    parameter int HEIGHT       = 100,
    parameter int MARGIN       = 15,
    parameter int START_Y      = (SCREEN_H - HEIGHT) / 2,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4,
    parameter int DEADBAND     = 2
) (
    input  logic                             i_CLK,
    input  logic                             i_RST_N,
    input  logic                             i_frame_tick,
    input  logic                             i_key_valid,
    input  logic [7:0]                       i_key_byte,
    input  logic                             i_ai_en,
    input  logic [Y_W-1:0]                   i_ball_y,
    output logic [Y_W-1:0]                   o_y_pos,
    output logic [$clog2(MAX_SPEED+1)-1:0]   o_speed,
    output logic [1:0]                       o_state,
    output logic                             o_at_top,
    output logic                             o_at_bot
);

    localparam int SW = $clog2(MAX_SPEED + 1);
    localparam int CW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    // One extra bit of headroom so y +/- step and ball_y - HEIGHT/2 never wrap.
    typedef logic signed [Y_W:0] sy_t;

    localparam sy_t Y_MIN_S  = sy_t'(MARGIN);
    localparam sy_t Y_MAX_S  = sy_t'(SCREEN_H - MARGIN - HEIGHT);
    localparam sy_t HALF_S   = sy_t'(HEIGHT / 2);
    localparam sy_t DBAND_S  = sy_t'(DEADBAND);
    localparam sy_t MAXSPD_S = sy_t'(MAX_SPEED);

    localparam logic [Y_W-1:0] Y_MIN_U   = Y_W'(MARGIN);
    localparam logic [Y_W-1:0] Y_MAX_U   = Y_W'(SCREEN_H - MARGIN - HEIGHT);
    localparam logic [Y_W-1:0] START_POS = Y_W'(START_Y);
    localparam logic [SW-1:0]  SPD_MAX   = SW'(MAX_SPEED);
    localparam logic [SW-1:0]  SPD_ONE   = SW'(1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(ACCEL_FRAMES - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    localparam logic [7:0] KEY_UP   = 8'(UP);
    localparam logic [7:0] KEY_DOWN = 8'(DOWN);
    localparam logic [7:0] KEY_STOP = 8'(STOP);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_UP   = 2'b01;
    localparam logic [1:0] ST_DOWN = 2'b10;
    localparam logic [1:0] ST_AI   = 2'b11;

    logic [1:0]     state_q, state_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [SW-1:0]  speed_q, speed_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ai_en_q, ai_en_d;

    // Signed views and candidate positions for this cycle's tick.
    sy_t y_s, spd_s, ball_s;
    sy_t step_up, step_dn;
    sy_t tgt_raw, tgt, diff, diff_abs, ai_step, ai_y;
    sy_t y_nxt;
    logic up_hit, dn_hit, ai_move;
    logic ai_rise, ai_fall;
    logic unused_y_msb;

    assign y_s    = $signed({1'b0, y_q});
    assign spd_s  = $signed({{(Y_W + 1 - SW){1'b0}}, speed_q});
    assign ball_s = $signed({1'b0, i_ball_y});

    // Key motion: a step that lands on or past the bound counts as a clamp hit.
    assign step_up = y_s - spd_s;
    assign step_dn = y_s + spd_s;
    assign up_hit  = (step_up <= Y_MIN_S);
    assign dn_hit  = (step_dn >= Y_MAX_S);

    // AI tracking: centre the paddle on the ball, clamped to the legal band.
    assign tgt_raw  = ball_s - HALF_S;
    assign tgt      = (tgt_raw < Y_MIN_S) ? Y_MIN_S :
                      (tgt_raw > Y_MAX_S) ? Y_MAX_S : tgt_raw;
    assign diff     = tgt - y_s;
    assign diff_abs = (diff < 0) ? -diff : diff;
    assign ai_move  = (diff_abs > DBAND_S);
    // Never step further than the distance left, so the target is not overshot.
    assign ai_step  = (diff_abs < MAXSPD_S) ? diff_abs : MAXSPD_S;
    assign ai_y     = (diff < 0) ? (y_s - ai_step) : (y_s + ai_step);

    assign ai_rise = i_ai_en & ~ai_en_q;
    assign ai_fall = ~i_ai_en & ai_en_q;

    // State register
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            y_q     <= START_POS;
            speed_q <= '0;
            cnt_q   <= '0;
            ai_en_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            ai_en_q <= ai_en_d;
        end
    end

    // Next state. Order matters: the tick moves using the registered state,
    // then a key updates the post-move state, then AI edges override both.
    always_comb begin
        state_d = state_q;
        y_nxt   = y_s;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        ai_en_d = i_ai_en;

        if (i_frame_tick) begin
            case (state_q)
                ST_UP, ST_DOWN: begin
                    if ((state_q == ST_UP) ? up_hit : dn_hit) begin
                        y_nxt   = (state_q == ST_UP) ? Y_MIN_S : Y_MAX_S;
                        state_d = ST_IDLE;
                        speed_d = '0;
                        cnt_d   = '0;
                    end else begin
                        y_nxt = (state_q == ST_UP) ? step_up : step_dn;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            if (speed_q < SPD_MAX) begin
                                speed_d = speed_q + SPD_ONE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_AI: begin
                    if (ai_move) begin
                        y_nxt = ai_y;
                    end
                end
                default: ;
            endcase
        end

        if (i_key_valid && (state_q != ST_AI)) begin
            // A repeat of the current direction is ignored so ramping continues.
            if (i_key_byte == KEY_UP) begin
                if (state_d != ST_UP) begin
                    state_d = ST_UP;
                    speed_d = SPD_ONE;
                    cnt_d   = '0;
                end
            end else if (i_key_byte == KEY_DOWN) begin
                if (state_d != ST_DOWN) begin
                    state_d = ST_DOWN;
                    speed_d = SPD_ONE;
                    cnt_d   = '0;
                end
            end else if (i_key_byte == KEY_STOP) begin
                state_d = ST_IDLE;
                speed_d = '0;
                cnt_d   = '0;
            end
        end

        if (ai_rise) begin
            state_d = ST_AI;
            speed_d = SPD_MAX;
            cnt_d   = '0;
        end else if (ai_fall) begin
            state_d = ST_IDLE;
            speed_d = '0;
            cnt_d   = '0;
        end

        y_d = y_nxt[Y_W-1:0];
    end

    // y_nxt is always within [Y_MIN, Y_MAX], so its sign bit is never needed.
    assign unused_y_msb = y_nxt[Y_W];

    // Outputs
    always_comb begin
        o_y_pos  = y_q;
        o_speed  = speed_q;
        o_state  = state_q;
        o_at_top = (y_q == Y_MIN_U);
        o_at_bot = (y_q == Y_MAX_U);
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - self-checking bench for paddle_ctrl
module tb_paddle_ctrl;

    localparam int YMIN  = 15;
    localparam int YMAX  = 365;
    localparam int START = 190;
    localparam int MAXS  = 8;
    localparam int ACC   = 4;
    localparam int DB    = 2;
    localparam int HALF  = 50;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       key_valid;
    logic [7:0] key_byte;
    logic       ai_en;
    logic [9:0] ball_y;
    logic [9:0] y_pos;
    logic [3:0] speed;
    logic [1:0] state;
    logic       at_top;
    logic       at_bot;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain integers, state 0 IDLE, 1 UP, 2 DOWN, 3 AI.
    int m_y, m_spd, m_st, m_cnt;
    bit m_ai_prev;

    paddle_ctrl dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_frame_tick (frame_tick),
        .i_key_valid  (key_valid),
        .i_key_byte   (key_byte),
        .i_ai_en      (ai_en),
        .i_ball_y     (ball_y),
        .o_y_pos      (y_pos),
        .o_speed      (speed),
        .o_state      (state),
        .o_at_top     (at_top),
        .o_at_bot     (at_bot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kv;
        int kb;
        int tick;
        int y;
        int spd;
        int st;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input int y, input int spd, input int st);
        chk({name, ".y"}, int'(y_pos), y);
        chk({name, ".speed"}, int'(speed), spd);
        chk({name, ".state"}, int'(state), st);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_y = START; m_spd = 0; m_st = 0; m_cnt = 0; m_ai_prev = 0;
    endtask

    task automatic model_step(input bit kv, input int kb, input bit tick, input bit ai, input int by);
        int ny, ns, nspd, ncnt, tgt, d, ad, mv;
        ny = m_y; ns = m_st; nspd = m_spd; ncnt = m_cnt;
        if (tick) begin
            if (m_st == 1 || m_st == 2) begin
                ny = (m_st == 1) ? imax(m_y - m_spd, YMIN) : imin(m_y + m_spd, YMAX);
                if ((m_st == 1 && ny == YMIN) || (m_st == 2 && ny == YMAX)) begin
                    ns = 0; nspd = 0; ncnt = 0;
                end else begin
                    ncnt = m_cnt + 1;
                    if (ncnt == ACC) begin
                        ncnt = 0;
                        nspd = imin(m_spd + 1, MAXS);
                    end
                end
            end else if (m_st == 3) begin
                tgt = imin(imax(by - HALF, YMIN), YMAX);
                d = tgt - m_y;
                ad = (d < 0) ? -d : d;
                if (ad > DB) begin
                    mv = imin(ad, MAXS);
                    ny = (d > 0) ? m_y + mv : m_y - mv;
                end
            end
        end
        if (kv && m_st != 3) begin
            if (kb == 119 && ns != 1) begin ns = 1; nspd = 1; ncnt = 0; end
            else if (kb == 115 && ns != 2) begin ns = 2; nspd = 1; ncnt = 0; end
            else if (kb == 32) begin ns = 0; nspd = 0; ncnt = 0; end
        end
        if (ai && !m_ai_prev) begin ns = 3; nspd = MAXS; ncnt = 0; end
        else if (!ai && m_ai_prev) begin ns = 0; nspd = 0; ncnt = 0; end
        m_ai_prev = ai;
        m_y = ny; m_st = ns; m_spd = nspd; m_cnt = ncnt;
    endtask

    // Drive one clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cycle(input bit kv, input logic [7:0] kb, input bit tick);
        key_valid  = kv;
        key_byte   = kb;
        frame_tick = tick;
        model_step(kv, int'(kb), tick, ai_en, int'(ball_y));
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; key_valid = 1'b0; key_byte = 8'd0; frame_tick = 1'b0;
        ai_en = 1'b0; ball_y = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Reset state held over idle ticks
        chk("reset.at_top", int'(at_top), 0);
        chk("reset.at_bot", int'(at_bot), 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 8'd0, 1);
            chk3("idle_ticks", START, 0, 0);
        end

        // Table: acceleration ramp, reversal, stop, stray key, repeated key
        tbl[0]  = '{1, 119, 0, 190, 1, 1};
        tbl[1]  = '{0, 0,   1, 189, 1, 1};
        tbl[2]  = '{0, 0,   1, 188, 1, 1};
        tbl[3]  = '{0, 0,   1, 187, 1, 1};
        tbl[4]  = '{0, 0,   1, 186, 2, 1};
        tbl[5]  = '{0, 0,   1, 184, 2, 1};
        tbl[6]  = '{0, 0,   1, 182, 2, 1};
        tbl[7]  = '{0, 0,   1, 180, 2, 1};
        tbl[8]  = '{0, 0,   1, 178, 3, 1};
        tbl[9]  = '{1, 115, 0, 178, 1, 2};
        tbl[10] = '{0, 0,   1, 179, 1, 2};
        tbl[11] = '{1, 32,  0, 179, 0, 0};
        tbl[12] = '{0, 0,   1, 179, 0, 0};
        tbl[13] = '{1, 120, 0, 179, 0, 0};
        tbl[14] = '{1, 115, 1, 179, 1, 2};
        tbl[15] = '{1, 115, 1, 180, 1, 2};
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].kv != 0, 8'(tbl[i].kb), tbl[i].tick != 0);
            chk3($sformatf("tbl[%0d]", i), tbl[i].y, tbl[i].spd, tbl[i].st);
        end

        // Ramp up into the top clamp
        do_reset();
        cycle(1, 8'd119, 0);
        for (int i = 0; i < 100 && state != 2'b00; i++) begin
            cycle(0, 8'd0, 1);
            if (int'(y_pos) < YMIN) chk("clamp.below_min", int'(y_pos), YMIN);
        end
        chk3("clamp", YMIN, 0, 0);
        chk("clamp.at_top", int'(at_top), 1);
        for (int i = 0; i < 3; i++) cycle(0, 8'd0, 1);
        chk("clamp.hold.y", int'(y_pos), YMIN);
        cycle(1, 8'd119, 0);
        chk("clamp.rekey.state", int'(state), 1);
        cycle(0, 8'd0, 1);
        chk3("clamp.rekey_tick", YMIN, 0, 0);

        // Reversal coincident with a tick at speed 3
        do_reset();
        cycle(1, 8'd119, 0);
        for (int i = 0; i < 8; i++) cycle(0, 8'd0, 1);
        chk3("rev.pre", 178, 3, 1);
        cycle(1, 8'd115, 1);
        chk3("rev.coincident", 175, 1, 2);
        cycle(0, 8'd0, 1);
        chk3("rev.next", 176, 1, 2);

        // AI tracking
        do_reset();
        ball_y = 10'd100;
        ai_en  = 1'b1;
        cycle(0, 8'd0, 0);
        chk3("ai.enter", START, MAXS, 3);
        cycle(1, 8'd119, 0);
        chk("ai.key_ignored", int'(state), 3);
        for (int k = 1; k <= 17; k++) begin
            cycle(0, 8'd0, 1);
            chk("ai.track", int'(y_pos), START - 8 * k);
        end
        cycle(0, 8'd0, 1);
        chk("ai.final_step", int'(y_pos), 50);
        ball_y = 10'd98;
        cycle(0, 8'd0, 1);
        chk("ai.dead_lo", int'(y_pos), 50);
        ball_y = 10'd102;
        cycle(0, 8'd0, 1);
        chk("ai.dead_hi", int'(y_pos), 50);
        ball_y = 10'd103;
        cycle(0, 8'd0, 1);
        chk("ai.outside_dead", int'(y_pos), 53);
        ball_y = 10'd20;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 8'd0, 1);
            if (int'(y_pos) < YMIN) chk("ai.below_min", int'(y_pos), YMIN);
        end
        chk("ai.top.y", int'(y_pos), YMIN);
        chk("ai.top.flag", int'(at_top), 1);
        ball_y = 10'd1000;
        for (int i = 0; i < 60; i++) cycle(0, 8'd0, 1);
        chk("ai.bot.y", int'(y_pos), YMAX);
        chk("ai.bot.flag", int'(at_bot), 1);
        ai_en = 1'b0;
        cycle(0, 8'd0, 0);
        chk3("ai.exit", YMAX, 0, 0);

        // Asynchronous reset mid-DOWN
        do_reset();
        cycle(1, 8'd115, 0);
        for (int i = 0; i < 100 && int'(y_pos) < 300; i++) cycle(0, 8'd0, 1);
        chk("areset.reached_300", int'(y_pos >= 10'd300), 1);
        chk("areset.pre_state", int'(state), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk3("areset.immediate", START, 0, 0);
        chk("areset.at_top", int'(at_top), 0);
        chk("areset.at_bot", int'(at_bot), 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        cycle(1, 8'd120, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'd0, 1);
        chk3("areset.stray_key", START, 0, 0);

        // Randomised run against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic       kv, tk;
            logic [7:0] kb;
            int         sel;
            if ($urandom_range(0, 63) == 0) ai_en = ~ai_en;
            if ($urandom_range(0, 15) == 0) ball_y = 10'($urandom_range(0, 600));
            kv  = ($urandom_range(0, 3) == 0);
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: kb = 8'd119;
                1: kb = 8'd115;
                2: kb = 8'd32;
                3: kb = 8'd120;
                default: kb = 8'($urandom_range(0, 255));
            endcase
            tk = ($urandom_range(0, 2) == 0);
            cycle(kv, kb, tk);
            chk("rnd.y", int'(y_pos), m_y);
            chk("rnd.speed", int'(speed), m_spd);
            chk("rnd.state", int'(state), m_st);
            chk("rnd.at_top", int'(at_top), int'(m_y == YMIN));
            chk("rnd.at_bot", int'(at_bot), int'(m_y == YMAX));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
